uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one `UART` transmitter half between `N` byte-stream requesters. Each grant can hold the transmitter for a burst of up to `MAX_BURST` octets or until the requester marks the last octet. The block sequences the `UART` `tx_ready_i`/`tx_ack_o` handshake so that every octet is presented to the transmitter exactly once. It sits between the requester logic (command responders, debug printers) and the `UART` instance in the top level.

## Interface
- `N`, 4: number of requesters, 2..8.
- `MAX_BURST`, 16: octets per grant before forced re-arbitration, 1..255; counter width is `$clog2(MAX_BURST+1)`.
- `clk` input 1: single clock, same clock as the `UART` `clk`.
- `reset` input 1: asynchronous, active-low.
- `req_i` input N: requester `i` has an octet pending on `data_i[8*i+7:8*i]`.
- `data_i` input 8N: per-requester octet. Must be stable while `req_i[i]` is high and until `ack_o[i]` is seen.
- `last_i` input N: the pending octet of requester `i` ends its burst.
- `ack_o` output N: one-cycle pulse; requester `i`'s current octet was consumed. The requester presents its next octet or drops `req_i` from the following cycle.
- `grant_o` output N: one-hot owner of the transmitter; all zeros when unowned.
- `busy_o` output 1: FSM not in `ARB`.
- `tx_data_o` output 8: to `UART` `tx_data_i`.
- `tx_ready_o` output 1: to `UART` `tx_ready_i`.
- `tx_ack_i` input 1: from `UART` `tx_ack_o` (high = transmitter idle).

## Operation
- All outputs are registered. Reset values: `ack_o`=0, `grant_o`=0, `busy_o`=0, `tx_data_o`=8'h00, `tx_ready_o`=0. Internal state on reset: FSM=`ARB`, round-robin pointer=0, burst count=0, latched last=0.
- **ARB**
  - Waits for `tx_ack_i`=1 and any `req_i` bit set.
  - Winner `g` = first set bit of `req_i` searching upward from the pointer, wrapping modulo N.
  - Registers: `grant_o`=1<<g, `tx_data_o`=`data_i[g]`, last=`last_i[g]`, count=1, `tx_ready_o`=1, `ack_o[g]`=1 for one cycle.
  - Goes to `WAIT_START`.
- **WAIT_START**
  - Holds `tx_ready_o`=1 and `tx_data_o` until `tx_ack_i`=0.
  - Then clears `tx_ready_o` and goes to `WAIT_DONE`.
- **WAIT_DONE**
  - Waits for `tx_ack_i`=1.
  - Continue the burst if `req_i[g]`=1, latched last=0 and count<`MAX_BURST`:
    - latch the next octet from `g`;
    - set `tx_ready_o`=1;
    - pulse `ack_o[g]`;
    - increment count;
    - go to `WAIT_START`.
  - Otherwise release:
    - `grant_o`=0;
    - pointer=(g+1) mod N;
    - go to `ARB`.
- A requester dropping `req_i` mid-burst is legal. The octet already acknowledged is still sent, and the grant is released at the next `WAIT_DONE` exit.
- `req_i` bits of non-owners are ignored while a grant is held. Requests raised in the same cycle are resolved by pointer order only.
- Exactly one `ack_o` bit is high in any cycle, or none. Every `ack_o` pulse corresponds to exactly one octet sent.
- A mid-operation `reset` returns everything to reset values immediately. The in-flight `UART` frame is not aborted by this block.

## Timing
- Grant latency: `req_i` seen in `ARB` at edge t (with `tx_ack_i`=1) gives `grant_o`, `ack_o` pulse and `tx_ready_o`=1 after edge t.
- `tx_ready_o` falls one cycle after `tx_ack_i` is sampled low. It is never high while the `UART` is returning to idle, so no octet is duplicated.
- Back-to-back octets within a burst: `tx_ready_o` rises one cycle after `tx_ack_i` returns high. There is no `ARB` cycle between octets.
- Re-arbitration costs one cycle: `WAIT_DONE` → `ARB` → grant.
- If `tx_ack_i`=0 while in `ARB`, the block stalls with no grant.

## Test plan
- **Single octet:** reset, then `req_i`=4'b0010, `data_i[15:8]`=8'hA5, `last_i[1]`=1.
  - `grant_o`=4'b0010, one `ack_o[1]` pulse, one `tx_ready_o` episode with `tx_data_o`=8'hA5.
  - `UART` line shows 0xA5 8n1; afterwards `grant_o`=0 and `busy_o`=0.
- **Fairness:** all four requesters hold `req_i` high with single-octet bursts (`last_i`=1) of 8'h10..8'h13.
  - Sent order is 10,11,12,13,10,… with exactly one octet each per rotation.
- **Burst limit:** `MAX_BURST`=3; requester 2 streams 5 octets with `last_i`=0 while requester 0 also requests.
  - Sent order is r2,r2,r2,r0…,r2,r2 (r2 resumes on its next turn).
  - Exactly 3 `ack_o[2]` pulses in the first grant.
- **Early release:** requester 3 drops `req_i` after its first `ack_o`.
  - The octet is still transmitted, then `grant_o`=0 and the pointer is 0.
- **Handshake stall:** hold `tx_ack_i`=0 externally with requests pending.
  - No grant and no `tx_ready_o`; on release the grant follows one cycle later.
- **Reset mid-burst:** assert `reset` in `WAIT_DONE`.
  - All outputs return to reset values asynchronously.
  - The next grant goes to the lowest requesting index.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter between N requesters.
// A grant holds the transmitter for up to MAX_BURST octets, or until the requester
// flags its last octet or drops its request. The tx_ready/tx_ack handshake is
// sequenced so that each acknowledged octet reaches the UART exactly once.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req_i[N]    - requester i has an octet pending on data_i[8*i+:8]
//   data_i[8N]  - per-requester octet
//   last_i[N]   - pending octet of requester i closes its burst
//   ack_o[N]    - one-cycle pulse: requester i's octet was consumed
//   grant_o[N]  - one-hot transmitter owner, zero when unowned
//   busy_o      - arbiter is not idle in the arbitration state
//   tx_data_o   - octet to the UART
//   tx_ready_o  - octet valid towards the UART
//   tx_ack_i    - UART idle indication
module uart_tx_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_i,
  input  logic [8*N-1:0] data_i,
  input  logic [N-1:0]   last_i,
  output logic [N-1:0]   ack_o,
  output logic [N-1:0]   grant_o,
  output logic           busy_o,
  output logic [7:0]     tx_data_o,
  output logic           tx_ready_o,
  input  logic           tx_ack_i
);

  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {StArb, StWaitStart, StWaitDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_q, last_d;
  logic [N-1:0]    ack_q, ack_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            busy_q, busy_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_ready_q, tx_ready_d;

  // Round-robin search: first set request at or above the pointer, wrapping.
  logic            win_valid;
  logic [IdxW-1:0] win_idx;
  int unsigned     cand;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr_q) + i) % N;
      if (!win_valid && req_i[IdxW'(cand)]) begin
        win_valid = 1'b1;
        win_idx   = IdxW'(cand);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    ack_d      = '0;
    grant_d    = grant_q;
    tx_data_d  = tx_data_q;
    tx_ready_d = tx_ready_q;

    unique case (state_q)
      StArb: begin
        if (tx_ack_i && win_valid) begin
          owner_d          = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          ack_d[win_idx]   = 1'b1;
          tx_data_d        = data_i[{win_idx, 3'b000} +: 8];
          last_d           = last_i[win_idx];
          cnt_d            = CntW'(1);
          tx_ready_d       = 1'b1;
          state_d          = StWaitStart;
        end
      end
      StWaitStart: begin
        // UART has taken the octet once it leaves idle.
        if (!tx_ack_i) begin
          tx_ready_d = 1'b0;
          state_d    = StWaitDone;
        end
      end
      StWaitDone: begin
        if (tx_ack_i) begin
          if (req_i[owner_q] && !last_q && (cnt_q < CntW'(MAX_BURST))) begin
            tx_data_d      = data_i[{owner_q, 3'b000} +: 8];
            last_d         = last_i[owner_q];
            ack_d[owner_q] = 1'b1;
            cnt_d          = cnt_q + CntW'(1);
            tx_ready_d     = 1'b1;
            state_d        = StWaitStart;
          end else begin
            grant_d = '0;
            ptr_d   = (owner_q == IdxW'(N - 1)) ? '0 : owner_q + IdxW'(1);
            state_d = StArb;
          end
        end
      end
      default: state_d = StArb;
    endcase

    busy_d = (state_d != StArb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StArb;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      ack_q      <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      ack_q      <= ack_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      tx_data_q  <= tx_data_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign ack_o      = ack_q;
  assign grant_o    = grant_q;
  assign busy_o     = busy_q;
  assign tx_data_o  = tx_data_q;
  assign tx_ready_o = tx_ready_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a behavioural UART with random
// frame lengths, and a round-robin/burst reference model of the expected send order.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int MB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req = '0, last_v = '0;
  logic [8*N-1:0] data = '0;
  logic [N-1:0]   ack, grant;
  logic           busy, tx_ready;
  logic           tx_ack = 1'b1;
  logic [7:0]     tx_data;

  uart_tx_arbiter #(.N(N), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .data_i    (data),
    .last_i    (last_v),
    .ack_o     (ack),
    .grant_o   (grant),
    .busy_o    (busy),
    .tx_data_o (tx_data),
    .tx_ready_o(tx_ready),
    .tx_ack_i  (tx_ack)
  );

  typedef struct packed {logic [7:0] d; logic l;} item_t;
  typedef struct packed {logic [7:0] idx; logic [7:0] d;} rec_t;

  item_t rq[N][$];
  rec_t  sent[$];
  rec_t  exp_q[$];
  int checks = 0, failures = 0;
  int acks = 0, ready_eps = 0, proto_err = 0;
  int uart_cnt = 0, gi = 0, m_ptr = 0;
  logic stall = 1'b0, uart_busy = 1'b0, prev_ready = 1'b0;

  // UART model, requester drivers and protocol monitor, all away from the active edge.
  always @(negedge clk) begin
    if (uart_busy) begin
      if (uart_cnt == 0) uart_busy = 1'b0;
      else uart_cnt--;
    end else if (tx_ready && !stall) begin
      gi = 255;
      for (int i = 0; i < N; i++) if (grant[i]) gi = i;
      sent.push_back('{idx: 8'(gi), d: tx_data});
      uart_busy = 1'b1;
      uart_cnt  = $urandom_range(1, 4);
    end
    tx_ack = !uart_busy && !stall;
    if (tx_ready && !prev_ready) ready_eps++;
    prev_ready = tx_ready;
    if ($countones(ack) > 1 || $countones(grant) > 1 || (ack & ~grant) != '0) proto_err++;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          acks++;
          if (rq[i].size() > 0) rq[i].delete(0);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      req[i]          = rq[i].size() > 0;
      data[8*i +: 8]  = (rq[i].size() > 0) ? rq[i][0].d : 8'h00;
      last_v[i]       = (rq[i].size() > 0) ? rq[i][0].l : 1'b0;
    end
  end

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (queues_empty() && !busy && !uart_busy && !tx_ready && ack == '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_log();
    @(posedge clk); #1;
    sent.delete();
    acks = 0;
    ready_eps = 0;
  endtask

  // Expected order: pick first non-empty queue from the pointer, send until the last
  // flag, the burst limit or an empty queue, then move the pointer past the owner.
  task automatic model_order(input item_t mq[N][$]);
    int g, n;
    bit stop;
    exp_q.delete();
    forever begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && mq[(m_ptr + k) % N].size() > 0) g = (m_ptr + k) % N;
      if (g < 0) break;
      n = 0;
      stop = 1'b0;
      while (!stop) begin
        exp_q.push_back('{idx: 8'(g), d: mq[g][0].d});
        n++;
        stop = mq[g][0].l || n == MB || mq[g].size() == 1;
        mq[g].delete(0);
      end
      m_ptr = (g + 1) % N;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (grant !== 4'h0) begin failures++; $display("FAIL rst_grant got=%h want=0", grant); end
    checks++; if (ack !== 4'h0) begin failures++; $display("FAIL rst_ack got=%h want=0", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_txdata got=%h want=00", tx_data); end
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL rst_txready got=%b want=0", tx_ready); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (grant !== 4'h0 || busy !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset grant=%h busy=%b want 0/0", grant, busy);
    end
  endtask

  task automatic test_fairness();
    bit ok;
    clear_log();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) rq[i].push_back('{d: 8'h10 + 8'(i), l: 1'b1});
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL fair_timeout done=%b want=1", ok); end
    checks++; if (sent.size() != 8) begin failures++; $display("FAIL fair_count got=%0d want=8", sent.size()); end
    for (int k = 0; k < sent.size() && k < 8; k++) begin
      checks++;
      if (sent[k].idx != 8'(k % 4) || sent[k].d != 8'h10 + 8'(k % 4)) begin
        failures++;
        $display("FAIL fair_order[%0d] got=r%0d/%h want=r%0d/%h", k, sent[k].idx, sent[k].d, k % 4, 8'h10 + 8'(k % 4));
      end
    end
    checks++; if (acks != 8) begin failures++; $display("FAIL fair_acks got=%0d want=8", acks); end
  endtask

  task automatic test_single();
    bit ok;
    bit seen = 1'b0;
    clear_log();
    rq[1].push_back('{d: 8'hA5, l: 1'b1});
    for (int n = 0; n < 50 && !seen; n++) begin
      @(posedge clk); #1;
      if (ack != '0) begin
        seen = 1'b1;
        checks++; if (ack !== 4'b0010 || grant !== 4'b0010 || tx_data !== 8'hA5 || tx_ready !== 1'b1) begin
          failures++;
          $display("FAIL single_grant ack=%b grant=%b data=%h rdy=%b want 0010/0010/a5/1", ack, grant, tx_data, tx_ready);
        end
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL single_ack_timeout seen=%b want=1", seen); end
    drain(ok);
    checks++; if (!ok || sent.size() != 1 || sent[0].d != 8'hA5 || sent[0].idx != 8'd1) begin
      failures++; $display("FAIL single_sent ok=%b n=%0d want one r1/a5", ok, sent.size());
    end
    checks++; if (acks != 1 || ready_eps != 1) begin
      failures++; $display("FAIL single_pulses acks=%0d eps=%0d want 1/1", acks, ready_eps);
    end
    checks++; if (grant !== 4'h0 || busy !== 1'b0) begin
      failures++; $display("FAIL single_release grant=%h busy=%b want 0/0", grant, busy);
    end
  endtask

  task automatic test_burst_limit();
    bit ok;
    logic [7:0] wi[7] = '{2, 2, 2, 0, 0, 2, 2};
    logic [7:0] wd[7] = '{8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h23, 8'h24};
    clear_log();
    for (int k = 0; k < 5; k++) rq[2].push_back('{d: 8'h20 + 8'(k), l: 1'b0});
    for (int k = 0; k < 2; k++) rq[0].push_back('{d: 8'h30 + 8'(k), l: 1'b0});
    drain(ok);
    checks++; if (!ok || sent.size() != 7) begin
      failures++; $display("FAIL burst_count ok=%b got=%0d want=7", ok, sent.size());
    end
    for (int k = 0; k < sent.size() && k < 7; k++) begin
      checks++;
      if (sent[k].idx != wi[k] || sent[k].d != wd[k]) begin
        failures++;
        $display("FAIL burst_order[%0d] got=r%0d/%h want=r%0d/%h", k, sent[k].idx, sent[k].d, wi[k], wd[k]);
      end
    end
  endtask

  task automatic test_early_release();
    bit ok;
    clear_log();
    rq[3].push_back('{d: 8'h3C, l: 1'b0});
    drain(ok);
    checks++; if (!ok || sent.size() != 1 || sent[0].d != 8'h3C || grant !== 4'h0) begin
      failures++; $display("FAIL early_sent ok=%b n=%0d grant=%h want one 3c and grant 0", ok, sent.size(), grant);
    end
    // Pointer now 0: r0 must beat r3 when both arrive together.
    clear_log();
    rq[0].push_back('{d: 8'h40, l: 1'b1});
    rq[3].push_back('{d: 8'h43, l: 1'b1});
    drain(ok);
    checks++; if (!ok || sent.size() != 2 || sent[0].idx != 8'd0 || sent[1].idx != 8'd3) begin
      failures++; $display("FAIL early_pointer n=%0d first=r%0d want r0 then r3", sent.size(), sent.size() > 0 ? sent[0].idx : 8'hff);
    end
  endtask

  task automatic test_stall();
    bit ok;
    clear_log();
    stall = 1'b1;
    rq[1].push_back('{d: 8'h77, l: 1'b1});
    repeat (8) @(posedge clk);
    #1;
    checks++; if (grant !== 4'h0 || tx_ready !== 1'b0 || ack !== 4'h0) begin
      failures++; $display("FAIL stall_hold grant=%h rdy=%b ack=%h want 0/0/0", grant, tx_ready, ack);
    end
    stall = 1'b0;
    @(negedge clk); #1;
    checks++; if (grant !== 4'h0) begin failures++; $display("FAIL stall_early grant=%h want=0", grant); end
    @(posedge clk); #1;
    checks++; if (grant !== 4'b0010 || tx_ready !== 1'b1) begin
      failures++; $display("FAIL stall_release grant=%b rdy=%b want 0010/1", grant, tx_ready);
    end
    drain(ok);
    checks++; if (!ok || sent.size() != 1 || sent[0].d != 8'h77) begin
      failures++; $display("FAIL stall_sent ok=%b n=%0d want one 77", ok, sent.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    item_t mq[N][$];
    int len;
    m_ptr = 2;
    for (int round = 0; round < 4; round++) begin
      clear_log();
      for (int i = 0; i < N; i++) begin
        mq[i].delete();
        len = $urandom_range(0, 6);
        for (int k = 0; k < len; k++)
          mq[i].push_back('{d: 8'($urandom), l: ($urandom_range(0, 3) == 0)});
      end
      model_order(mq);
      for (int i = 0; i < N; i++) rq[i] = mq[i];
      drain(ok);
      checks++; if (!ok || sent.size() != exp_q.size()) begin
        failures++; $display("FAIL rand_count round=%0d got=%0d want=%0d", round, sent.size(), exp_q.size());
      end
      for (int k = 0; k < sent.size() && k < exp_q.size(); k++) begin
        checks++;
        if (sent[k] != exp_q[k]) begin
          failures++;
          $display("FAIL rand_order r%0d[%0d] got=r%0d/%h want=r%0d/%h", round, k, sent[k].idx, sent[k].d, exp_q[k].idx, exp_q[k].d);
        end
      end
      checks++; if (acks != exp_q.size()) begin
        failures++; $display("FAIL rand_acks got=%0d want=%0d", acks, exp_q.size());
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    bit hit = 1'b0;
    clear_log();
    for (int k = 0; k < 3; k++) rq[2].push_back('{d: 8'h50 + 8'(k), l: 1'b0});
    for (int n = 0; n < 200 && !hit; n++) begin
      @(posedge clk); #1;
      if (busy && !tx_ready) hit = 1'b1;
    end
    checks++; if (!hit) begin failures++; $display("FAIL mid_wait_done hit=%b want=1", hit); end
    rst_n = 1'b0;
    #1;
    checks++; if (grant !== 4'h0 || ack !== 4'h0 || busy !== 1'b0 || tx_data !== 8'h00 || tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset grant=%h ack=%h busy=%b data=%h rdy=%b want all 0", grant, ack, busy, tx_data, tx_ready);
    end
    for (int i = 0; i < N; i++) rq[i].delete();
    repeat (2) @(posedge clk);
    #1;
    sent.delete();
    acks = 0;
    rq[3].push_back('{d: 8'h63, l: 1'b1});
    rq[1].push_back('{d: 8'h61, l: 1'b1});
    @(posedge clk); #3;
    rst_n = 1'b1;
    drain(ok);
    checks++; if (!ok || sent.size() != 2 || sent[0].idx != 8'd1 || sent[1].idx != 8'd3) begin
      failures++; $display("FAIL mid_regrant n=%0d first=r%0d want r1 then r3", sent.size(), sent.size() > 0 ? sent[0].idx : 8'hff);
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_burst_limit();
    test_early_release();
    test_stall();
    test_random();
    test_reset_mid_burst();
    checks++; if (proto_err != 0) begin failures++; $display("FAIL protocol_onehot errors=%0d want=0", proto_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
